// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU M-stage has absolute priority,
// aux requester is served through a one-entry hold register.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  input  logic [3:0]  aux_byteen,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        aux_starve,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic             h_we;
  logic [31:0]      h_addr;
  logic [31:0]      h_wdata;
  logic [3:0]       h_byteen;

  logic             cpu_act;
  logic             accept;
  logic             issue;

  assign cpu_act    = cpu_re | (|cpu_byteen);
  assign aux_ready  = (state == IDLE) & reset;
  assign accept     = aux_valid & aux_ready;
  assign issue      = (state == PEND) & ~cpu_act;

  assign cpu_rdata  = mem_rdata;
  assign aux_rvalid = (state == RESP);
  assign aux_rdata  = aux_rvalid ? mem_rdata : 32'h0;
  assign aux_starve = (cnt == LIM);

  // Next state and starvation counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = PEND;
      end
      PEND: begin
        if (cpu_act) begin
          if (cnt != LIM) cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx   = '0;
          state_nx = h_we ? IDLE : RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Hold register captures the aux request on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_we     <= 1'b0;
      h_addr   <= '0;
      h_wdata  <= '0;
      h_byteen <= '0;
    end else if (accept) begin
      h_we     <= aux_we;
      h_addr   <= {aux_addr[31:2], 2'b00};
      h_wdata  <= aux_wdata;
      h_byteen <= aux_byteen;
    end
  end

  // Memory port mux: CPU first, then pending aux issue
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    unique case (1'b1)
      cpu_act: begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_byteen = cpu_byteen;
      end
      issue: begin
        mem_addr   = h_addr;
        mem_wdata  = h_wdata;
        mem_byteen = h_we ? h_byteen : 4'h0;
      end
      default: ;
    endcase
  end

endmodule
